// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//
// SPI master (mode 0, MSB first) issuing 16-bit register-write frames.
// Each accepted request {addr[6:0], data[7:0]} is sent as the frame
// {1'b1, addr, data}. The controller enforces chip-select setup, hold and
// inter-frame gap times, all counted in system clock cycles.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   req_valid in   write request present
//   req_ready out  controller idle; accept on req_valid && req_ready
//   req_addr  in   7-bit register address
//   req_data  in   8-bit register data
//   busy      out  frame in progress (not IDLE)
//   done      out  one-cycle pulse after a frame and its gap complete
//   sclk      out  SPI clock, idles low
//   ncs       out  chip select, active low
//   copi      out  serial data, MSB first
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Wide enough for the largest of the setup/hold/gap counts.
  localparam int CNT_W = $clog2(CS_SETUP + CS_HOLD + CS_GAP + 1);

  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;    // setup / hold / gap cycle counter
  logic [PH_W-1:0]  ph_q;     // cycles within the current SCLK half-period
  logic [3:0]       bit_q;    // index of the bit being transmitted
  logic [15:0]      shift_q;  // MSB is the bit currently on copi
  logic             sclk_q;
  logic             ncs_q;
  logic             done_q;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  // copi comes straight from the shift register MSB, so it only moves when
  // the register is loaded (accept), shifted (SCLK fall) or cleared (ncs rise).
  assign copi      = shift_q[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          ncs_q  <= 1'b1;
          if (req_valid) begin
            shift_q <= {1'b1, req_addr, req_data};
            ncs_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        SHIFT: begin
          if (ph_q == PH_LAST) begin
            ph_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 4'd15) begin
                // Last bit stays on copi through HOLD.
                cnt_q   <= '0;
                state_q <= HOLD;
              end else begin
                bit_q   <= bit_q + 1'b1;
                shift_q <= {shift_q[14:0], 1'b0};
              end
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end

        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            ncs_q   <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//
// Self-checking bench for spi_controller. A pin-level monitor reconstructs
// every frame from copi at SCLK rising edges and measures ncs low time,
// inter-frame gap and accept-to-done latency in clk cycles; the stimulus
// compares these against values derived from the frame format and the
// timing parameters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;

  localparam int EXP_LOW = CS_SETUP + 32*CLK_DIV + CS_HOLD;
  localparam int EXP_LAT = EXP_LOW + CS_GAP;
  localparam int LIMIT   = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       ncs;
  logic       copi;

  spi_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .busy     (busy),
    .done     (done),
    .sclk     (sclk),
    .ncs      (ncs),
    .copi     (copi)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int          cyc = 0;
  int          nfall = 0, nrise = 0, ndone = 0;
  int          cur_bits = 0;
  logic [15:0] cur_frame = '0;
  int          fall_cyc = 0, rise_cyc = 0;
  int          copi_stable = 0;
  int          stab_viol = 0, idle_viol = 0, done_long = 0;
  logic [15:0] cap_frame [64];
  int          cap_bits  [64];
  int          cap_low   [64];
  int          cap_gap   [64];
  int          cap_pdone [64];
  int          done_lat  [64];

  initial begin
    logic prev_sclk, prev_ncs, prev_copi, prev_done;
    prev_sclk = 1'b0; prev_ncs = 1'b1; prev_copi = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (copi == prev_copi) copi_stable++;
      else copi_stable = 1;
      if (prev_ncs && !ncs) begin
        cap_gap[nfall % 64]   = (nrise > 0) ? cyc - rise_cyc : -1;
        cap_pdone[nfall % 64] = int'(prev_done);
        fall_cyc  = cyc;
        cur_bits  = 0;
        cur_frame = '0;
        nfall++;
      end
      if (!ncs && !prev_sclk && sclk) begin
        cur_frame = {cur_frame[14:0], copi};
        cur_bits++;
        // copi must have held for a full low phase before this rising edge
        if (copi_stable < CLK_DIV + 1) stab_viol++;
      end
      if (ncs && sclk) idle_viol++;
      if (!prev_ncs && ncs) begin
        cap_frame[nrise % 64] = cur_frame;
        cap_bits[nrise % 64]  = cur_bits;
        cap_low[nrise % 64]   = cyc - fall_cyc;
        rise_cyc = cyc;
        nrise++;
      end
      if (done) begin
        if (prev_done) done_long++;
        done_lat[ndone % 64] = cyc - fall_cyc;
        ndone++;
      end
      prev_sclk = sclk; prev_ncs = ncs; prev_copi = copi; prev_done = done;
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", int'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 7'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (ndone < target && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (ndone < target) check("done_timeout", ndone, target);
  endtask

  task automatic check_frame(input string tag, input int idx, input int exp_frame);
    check({tag, "_frame"}, int'(cap_frame[idx % 64]), exp_frame);
    check({tag, "_bits"},  cap_bits[idx % 64], 16);
    check({tag, "_ncs_low"}, cap_low[idx % 64], EXP_LOW);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs [5];

  // -------------------------------------------------------------- stimulus
  initial begin
    int base_d, base_f, base_r;
    logic [6:0] ra;
    logic [7:0] rd;

    vecs[0] = '{7'h00, 8'hA5, 16'h80A5};
    vecs[1] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[2] = '{7'h04, 8'hFF, 16'h84FF};
    vecs[3] = '{7'h01, 8'h3C, 16'h813C};
    vecs[4] = '{7'h03, 8'hC3, 16'h83C3};

    // Reset idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ncs",   int'(ncs), 1);
    check("rst_sclk",  int'(sclk), 0);
    check("rst_copi",  int'(copi), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);

    // Directed single writes from the table
    for (int i = 0; i < 5; i++) begin
      base_d = ndone;
      send(vecs[i].addr, vecs[i].data);
      check("vec_busy", int'(busy), 1);
      wait_done(base_d + 1);
      check_frame("vec", nrise - 1, int'(vecs[i].exp_frame));
      check("vec_latency", done_lat[(ndone - 1) % 64], EXP_LAT);
    end

    // Back-to-back: req_valid held high across both frames
    base_d = ndone;
    base_f = nfall;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 7'h01;
    req_data  = 8'h3C;
    @(negedge clk);
    req_addr  = 7'h03;
    req_data  = 8'hC3;
    for (int t = 0; t < LIMIT && nfall < base_f + 2; t++) @(negedge clk);
    req_valid = 1'b0;
    wait_done(base_d + 2);
    check_frame("b2b1", base_f, 16'h813C);
    check_frame("b2b2", base_f + 1, 16'h83C3);
    check("b2b_gap", cap_gap[(base_f + 1) % 64], CS_GAP + 1);
    check("b2b_accept_in_done", cap_pdone[(base_f + 1) % 64], 1);
    check("b2b_latency", done_lat[(ndone - 1) % 64], EXP_LAT);

    // Busy lockout: new request pulsed mid-frame must be ignored
    base_d = ndone;
    base_f = nfall;
    send(7'h2A, 8'h55);
    for (int t = 0; t < LIMIT && cur_bits < 4; t++) @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 7'h11;
    req_data  = 8'hEE;
    check("lock_ready", int'(req_ready), 0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(base_d + 1);
    repeat (10) @(negedge clk);
    check_frame("lock", base_f, 16'hAA55);
    check("lock_no_extra_frame", nfall, base_f + 1);

    // Reset mid-frame after the 8th SCLK rise
    base_r = nrise;
    base_d = ndone;
    send(7'h22, 8'h99);
    for (int t = 0; t < LIMIT && cur_bits < 8; t++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ncs",  int'(ncs), 1);
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_partial_bits", cap_bits[base_r % 64], 8);
    check("midrst_no_done", ndone, base_d);
    base_d = ndone;
    base_f = nfall;
    send(7'h05, 8'h5A);
    wait_done(base_d + 1);
    check_frame("post_rst", base_f, 16'h855A);

    // Randomized writes against the frame-format model
    for (int i = 0; i < 12; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      base_d = ndone;
      base_f = nfall;
      send(ra, rd);
      wait_done(base_d + 1);
      check_frame("rand", base_f, 32'h8000 + int'(ra) * 256 + int'(rd));
      check("rand_latency", done_lat[(ndone - 1) % 64], EXP_LAT);
    end

    // Pin-level invariants accumulated over the whole run
    check("copi_stable_before_rise", stab_viol, 0);
    check("sclk_low_while_ncs_high", idle_viol, 0);
    check("done_single_cycle", done_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
